mul_div_unit: RTL

//  Iterative RV32M multiply/divide unit in the execute stage, downstream of the register file.

---
 rtl/mul_div_unit_pkg.sv | 37 +++
 rtl/mul_div_unit_sign_fix.sv | 16 +
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   op_e     : funct3 operation codes (MUL..REMU)
//   state_e  : sequencer states IDLE/RUN/FIX/DONE
//   REGISTER_WIDTH / REG_INDEX_WIDTH : register-file widths used as defaults
//   op_a_signed / op_b_signed : which operands are treated as two's complement
package mul_div_unit_pkg;

  localparam int REGISTER_WIDTH  = 32;
  localparam int REG_INDEX_WIDTH = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_a_signed(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate.
// Used to take operand magnitudes at accept and to restore result sign in FIX.
//   i_val [W]  value in
//   i_neg      negate when high
//   o_val [W]  i_neg ? -i_val : i_val (wraps modulo 2^W)
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one radix-2 step per cycle.
//   clk, rst        clock; synchronous active-high reset
//   start           request, accepted only when idle
//   op              funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   operand_a/b     rs1 / rs2 values, captured on accept
//   rd_index_in     destination index, captured on accept
//   busy            sequencer not idle
//   done / wr_en    one-cycle result strobe to the register file
//   result          final value, held until overwritten by a later operation
//   wr_reg_index    captured destination index
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = REGISTER_WIDTH,
  parameter int IDX_W = REG_INDEX_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [IDX_W-1:0] rd_index_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_reg_index
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e             r_state;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*XLEN-1:0]  r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [XLEN-1:0]    r_opb;     // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic               r_neg;
  logic [XLEN-1:0]    r_result;
  logic [IDX_W-1:0]   r_rd;

  op_e                w_op;
  logic               w_sgn_a, w_sgn_b;
  logic [XLEN-1:0]    w_mag_a, w_mag_b;
  logic               w_fast;
  logic [XLEN-1:0]    w_fast_res;
  logic [XLEN:0]      w_sum;
  logic               w_ge;
  logic [XLEN-1:0]    w_diff;
  logic [2*XLEN-1:0]  w_step;
  logic [2*XLEN-1:0]  w_fix_in, w_fix_out;
  logic [XLEN-1:0]    w_fix_res;

  assign w_op    = op_e'(op);
  assign w_sgn_a = operand_a[XLEN-1] & op_a_signed(w_op);
  assign w_sgn_b = operand_b[XLEN-1] & op_b_signed(w_op);

  mdu_sign_fix #(.W(XLEN)) u_fix_a (.i_val(operand_a), .i_neg(w_sgn_a), .o_val(w_mag_a));
  mdu_sign_fix #(.W(XLEN)) u_fix_b (.i_val(operand_b), .i_neg(w_sgn_b), .o_val(w_mag_b));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
    if (op[2]) begin
      if (operand_b == '0) begin
        w_fast     = 1'b1;
        w_fast_res = op[1] ? operand_a : '1;
      end else if ((w_op == OP_DIV || w_op == OP_REM) &&
                   operand_a == MIN_INT && operand_b == '1) begin
        w_fast     = 1'b1;
        w_fast_res = op[1] ? '0 : MIN_INT;
      end
    end
  end

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : '0)};

  // Restoring divide step: trial-subtract the divisor from the shifted remainder.
  // When the trial succeeds the true difference fits XLEN bits, so the low bits suffice.
  assign w_ge   = r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opb};
  assign w_diff = r_acc[2*XLEN-2:XLEN-1] - r_opb;

  always_comb begin
    if (r_op[2])
      w_step = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
    else
      w_step = {w_sum, r_acc[XLEN-1:1]};
  end

  // One wide negate serves all ops: the quotient/remainder is zero-extended first
  // so the low half of the negated value is its XLEN-bit negation.
  always_comb begin
    if (!r_op[2])
      w_fix_in = r_acc;
    else if (r_op[1])
      w_fix_in = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
    else
      w_fix_in = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
  end

  mdu_sign_fix #(.W(2*XLEN)) u_fix_res (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fix_out));

  assign w_fix_res = (r_op == OP_MUL || r_op[2]) ? w_fix_out[XLEN-1:0]
                                                 : w_fix_out[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op  <= w_op;
            r_rd  <= rd_index_in;
            r_cnt <= '0;
            r_acc <= {{XLEN{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
            r_opb <= op[2] ? w_mag_b : w_mag_a;
            r_neg <= (op[2] && op[1]) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(XLEN-1))
            r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix_res;
          r_state  <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign wr_en        = done;
  assign result       = r_result;
  assign wr_reg_index = r_rd;

endmodule
